branch_predictor_btb: RTL and testbench
=======================================

// Module: branch_predictor_btb
// PURPOSE
//  Dynamic branch predictor for the pipelined CPU: a direct-mapped branch target buffer (BTB)
//  with a 2-bit saturating counter per entry. It replaces static fall-through fetch.
//  IF looks up the current PC combinationally to get a predicted next PC.
//  ID/EX reports the resolved branch outcome. The block updates its tables, flags a
//  mispredict and supplies the corrected PC for flush and redirect.
// PARAMETERS
//  ADDR_W   16  PC / target width in bits
//  DEPTH     8  BTB entries; power of 2, >= 2
//  IDX_W     $clog2(DEPTH)  index width; localparam, derived
// PORTS
//  clk              in   1       system clock; all state updates on posedge
//  rst              in   1       synchronous reset, active-high
//  IF_PC            in   ADDR_W  PC of the instruction being fetched
//  IF_hit           out  1       valid tag match for IF_PC
//  IF_pred_taken    out  1       IF_hit & counter[1]
//  IF_pred_PC       out  ADDR_W  IF_pred_taken ? stored target : IF_PC+2
//  ID_update        in   1       a branch (B or BR) resolves this cycle
//  ID_PC            in   ADDR_W  PC of the resolving branch
//  ID_actual_taken  in   1       resolved condition (condition met & Branch)
//  ID_actual_target in   ADDR_W  resolved target (PC+2+(imm<<1), or Rs for BR)
//  ID_pred_taken    in   1       prediction carried down the pipe with the branch
//  ID_pred_PC       in   ADDR_W  predicted next PC carried down the pipe
//  mispredicted     out  1       comb; asserted only when ID_update=1
//  correct_PC       out  ADDR_W  ID_actual_taken ? ID_actual_target : ID_PC+2
//  stat_branches    out  16      resolved-branch count (see CONFIGURATION)
//  stat_mispredicts out  16      mispredict count (see CONFIGURATION)
// BEHAVIOUR
//  - Indexing: idx = PC[IDX_W:1] (PC[0] ignored, half-word aligned). tag = PC[ADDR_W-1:IDX_W+1].
//  - Entry fields: valid, tag, target[ADDR_W], cnt[2].
//    Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
//  - Lookup is purely combinational from the registered arrays; zero-cycle latency.
//  - Misprediction: mispredicted = ID_update & ((ID_pred_taken != ID_actual_taken) |
//    (ID_actual_taken & ID_pred_PC != ID_actual_target)). PC adds wrap modulo 2^ADDR_W.
//  - Update at posedge when ID_update=1 and rst=0:
//    * Hit, taken:     cnt = sat_inc(cnt); target <= ID_actual_target.
//    * Hit, not taken: cnt = sat_dec(cnt); target unchanged.
//    * Miss, taken:    allocate (overwrite) entry: valid=1, tag, target, cnt=10 (WT).
//    * Miss, not taken: no write.
//  - Saturation: 11+taken stays 11; 00+not-taken stays 00.
//  - Simultaneous lookup and update of the same index: IF sees pre-update contents. The new
//    contents are visible from the next cycle. No bypass.
//  - Aliasing: a different tag at the same index is a miss. A taken update evicts the old entry.
//  - Reset: all valid=0, cnt=01, tag/target=0. Outputs then read IF_hit=0,
//    IF_pred_taken=0, IF_pred_PC=IF_PC+2. rst dominates ID_update in the same cycle.
//    A reset mid-stream discards all history.
//  - Stalls: the caller deasserts ID_update while a stalled branch is held. The block has no
//    internal stall logic.
// CONFIGURATION
//  - Macro BP_STATS_EN:
//    * Defined: two 16-bit counters increment on posedge. stat_branches on each
//      ID_update; stat_mispredicts on each ID_update & mispredicted. Both saturate at 16'hFFFF.
//      Both clear to 0 on rst.
//    * Not defined: no counter flops; both stat ports tie to 16'h0000. Ports always exist.
// TESTING (DEPTH=8: idx=PC[3:1], tag=PC[15:4])
//  1. rst, then IF_PC=0x0010 -> IF_hit=0, IF_pred_taken=0, IF_pred_PC=0x0012.
//  2. ID_update, PC=0x0010, taken, target 0x0040, pred_taken=0 -> mispredicted=1,
//     correct_PC=0x0040. Next cycle IF_PC=0x0010 -> hit=1, taken=1, pred_PC=0x0040.
//  3. Three not-taken updates at 0x0010 -> cnt 10->01->00->00. IF_pred_taken=0 after the first,
//     IF_pred_PC=0x0012. Then two taken updates -> 01, 10 -> predict taken.
//  4. Taken update at 0x0030 (same idx 0, tag differs) -> evicts 0x0010. Lookup 0x0010 -> hit=0.
//     Not-taken update at miss 0x0050 -> no write; entry for 0x0030 intact.
//  5. Same cycle: ID_update for 0x0010 with new target 0x0080, IF_PC=0x0010 -> IF_pred_PC=old
//     0x0040. Next cycle 0x0080. Taken, pred_PC=0x0040, target 0x0080 -> mispredicted=1.
//  6. rst=1 with ID_update=1 -> no allocation; next lookup misses. With BP_STATS_EN, stats
//     read 0. After 3 updates with 2 mispredicts -> 3/2. Forced to 0xFFFF -> holds.

Source files
------------

// File: rtl/branch_predictor_btb_if.sv
// Fetch/resolve bus between the CPU pipeline (master) and the branch predictor (slave).
// Signal names mirror the original flat port list of branch_predictor_btb.
interface branch_predictor_btb_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              IF_hit;
  logic              IF_pred_taken;
  logic [ADDR_W-1:0] IF_PC;
  logic [ADDR_W-1:0] IF_pred_PC;

  logic              ID_update;
  logic [ADDR_W-1:0] ID_PC;
  logic              ID_actual_taken;
  logic [ADDR_W-1:0] ID_actual_target;
  logic              ID_pred_taken;
  logic [ADDR_W-1:0] ID_pred_PC;

  logic              mispredicted;
  logic [ADDR_W-1:0] correct_PC;
  logic [15:0]       stat_branches;
  logic [15:0]       stat_mispredicts;

  modport master (
    output IF_PC, ID_update, ID_PC, ID_actual_taken, ID_actual_target,
           ID_pred_taken, ID_pred_PC,
    input  IF_hit, IF_pred_taken, IF_pred_PC, mispredicted, correct_PC,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  IF_PC, ID_update, ID_PC, ID_actual_taken, ID_actual_target,
           ID_pred_taken, ID_pred_PC,
    output IF_hit, IF_pred_taken, IF_pred_PC, mispredicted, correct_PC,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry; combinational IF lookup.
// Optional macro BP_STATS_EN adds saturating resolved-branch / mispredict counters.
module branch_predictor_btb #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predictor_btb_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 1;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  function automatic cnt_t sat_inc(input cnt_t c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic cnt_t sat_dec(input cnt_t c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  cnt_t              cnt_q    [DEPTH];

  logic [IDX_W-1:0]  if_idx;
  logic [TAG_W-1:0]  if_tag;
  logic [IDX_W-1:0]  id_idx;
  logic [TAG_W-1:0]  id_tag;
  logic              if_hit;
  logic              if_taken;
  logic              id_hit;
  logic              mispredict;

  // PC[0] is ignored: instructions are half-word aligned.
  assign if_idx = bp.IF_PC[IDX_W:1];
  assign if_tag = bp.IF_PC[ADDR_W-1:IDX_W+1];
  assign id_idx = bp.ID_PC[IDX_W:1];
  assign id_tag = bp.ID_PC[ADDR_W-1:IDX_W+1];

  // Lookup reads the registered arrays only, so a same-cycle update is not bypassed.
  assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_taken = if_hit && (cnt_q[if_idx] inside {WT, ST});
  assign id_hit   = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  assign bp.IF_hit        = if_hit;
  assign bp.IF_pred_taken = if_taken;
  assign bp.IF_pred_PC    = if_taken ? target_q[if_idx] : bp.IF_PC + ADDR_W'(2);

  assign mispredict = bp.ID_update &
                      ((bp.ID_pred_taken != bp.ID_actual_taken) |
                       (bp.ID_actual_taken & (bp.ID_pred_PC != bp.ID_actual_target)));

  assign bp.mispredicted = mispredict;
  assign bp.correct_PC   = bp.ID_actual_taken ? bp.ID_actual_target
                                              : bp.ID_PC + ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i[IDX_W-1:0]]    <= '0;
        target_q[i[IDX_W-1:0]] <= '0;
        cnt_q[i[IDX_W-1:0]]    <= WNT;
      end
    end else if (bp.ID_update) begin
      if (id_hit) begin
        if (bp.ID_actual_taken) begin
          cnt_q[id_idx]    <= sat_inc(cnt_q[id_idx]);
          target_q[id_idx] <= bp.ID_actual_target;
        end else begin
          cnt_q[id_idx] <= sat_dec(cnt_q[id_idx]);
        end
      end else if (bp.ID_actual_taken) begin
        // Taken miss allocates, evicting whatever aliased into this index.
        valid_q[id_idx]  <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= bp.ID_actual_target;
        cnt_q[id_idx]    <= WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] branches_q;
  logic [15:0] mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (bp.ID_update) begin
      if (branches_q != '1) branches_q <= branches_q + 16'd1;
      if (mispredict && (mispredicts_q != '1)) mispredicts_q <= mispredicts_q + 16'd1;
    end
  end

  assign bp.stat_branches    = branches_q;
  assign bp.stat_mispredicts = mispredicts_q;
`else
  assign bp.stat_branches    = '0;
  assign bp.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed cases then random traffic,
// compared against an array-based model of the BTB rules.
module tb_branch_predictor_btb;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic clk;
  logic rst;

  branch_predictor_btb_if #(.ADDR_W(16)) bus ();

  branch_predictor_btb #(.ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers per BTB slot, counter as 0..3.
  int m_valid [DEPTH];
  int m_tag   [DEPTH];
  int m_tgt   [DEPTH];
  int m_cnt   [DEPTH];
  int m_br;
  int m_mp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input int pc);
    return (pc >> 1) % DEPTH;
  endfunction

  function automatic int tagof(input int pc);
    return pc >> (IDX_W + 1);
  endfunction

  function automatic int m_hit(input int pc);
    return (m_valid[slot(pc)] != 0 && m_tag[slot(pc)] == tagof(pc)) ? 1 : 0;
  endfunction

  function automatic int m_taken(input int pc);
    return (m_hit(pc) != 0 && m_cnt[slot(pc)] >= 2) ? 1 : 0;
  endfunction

  function automatic int m_pred_pc(input int pc);
    return (m_taken(pc) != 0) ? m_tgt[slot(pc)] : ((pc + 2) % 65536);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  // One cycle: drive, check combinational outputs against pre-edge model, then advance.
  task automatic step(input logic r, input logic upd, input int if_pc, input int id_pc,
                      input logic act, input int tgt, input logic pt, input int ppc);
    int exp_misp, exp_corr, s;
    @(negedge clk);
    rst                  = r;
    bus.IF_PC            = 16'(if_pc);
    bus.ID_update        = upd;
    bus.ID_PC            = 16'(id_pc);
    bus.ID_actual_taken  = act;
    bus.ID_actual_target = 16'(tgt);
    bus.ID_pred_taken    = pt;
    bus.ID_pred_PC       = 16'(ppc);
    #1;
    exp_misp = (upd && (pt != act || (act && ppc != tgt))) ? 1 : 0;
    exp_corr = act ? tgt : ((id_pc + 2) % 65536);
    check_eq("if_hit",       32'(bus.IF_hit),        32'(m_hit(if_pc)));
    check_eq("if_pred_taken", 32'(bus.IF_pred_taken), 32'(m_taken(if_pc)));
    check_eq("if_pred_pc",   32'(bus.IF_pred_PC),    32'(m_pred_pc(if_pc)));
    check_eq("mispredicted", 32'(bus.mispredicted),  32'(exp_misp));
    check_eq("correct_pc",   32'(bus.correct_PC),    32'(exp_corr));
`ifdef BP_STATS_EN
    check_eq("stat_branches",    32'(bus.stat_branches),    32'(m_br));
    check_eq("stat_mispredicts", 32'(bus.stat_mispredicts), 32'(m_mp));
`else
    check_eq("stat_branches",    32'(bus.stat_branches),    32'd0);
    check_eq("stat_mispredicts", 32'(bus.stat_mispredicts), 32'd0);
`endif
    if (r) begin
      m_reset();
    end else if (upd) begin
      s = slot(id_pc);
      if (m_hit(id_pc) != 0) begin
        if (act) begin
          m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
          m_tgt[s] = tgt;
        end else begin
          m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
        end
      end else if (act) begin
        m_valid[s] = 1; m_tag[s] = tagof(id_pc); m_tgt[s] = tgt; m_cnt[s] = 2;
      end
      if (m_br < 65535) m_br++;
      if (exp_misp != 0 && m_mp < 65535) m_mp++;
    end
    @(posedge clk);
  endtask

  initial begin
    int pc_if, pc_id, tgt, ppc;
    logic act, pt, upd, r;
    rst = 1'b1;
    bus.IF_PC = '0; bus.ID_update = 1'b0; bus.ID_PC = '0; bus.ID_actual_taken = 1'b0;
    bus.ID_actual_target = '0; bus.ID_pred_taken = 1'b0; bus.ID_pred_PC = '0;
    m_reset();

    // Reset, then cold lookup.
    step(1, 0, 'h10, 0, 0, 0, 0, 0);
    step(0, 0, 'h10, 0, 0, 0, 0, 0);
    // Taken miss allocates; lookup sees it next cycle.
    step(0, 1, 'h10, 'h10, 1, 'h40, 0, 'h12);
    step(0, 0, 'h10, 0, 0, 0, 0, 0);
    // Counter walks down and saturates, then back up.
    step(0, 1, 'h10, 'h10, 0, 'h40, 1, 'h40);
    step(0, 1, 'h10, 'h10, 0, 'h40, 0, 'h12);
    step(0, 1, 'h10, 'h10, 0, 'h40, 0, 'h12);
    step(0, 1, 'h10, 'h10, 1, 'h40, 0, 'h12);
    step(0, 1, 'h10, 'h10, 1, 'h40, 0, 'h12);
    step(0, 0, 'h10, 0, 0, 0, 0, 0);
    // Aliasing eviction and not-taken miss.
    step(0, 1, 'h10, 'h30, 1, 'h60, 0, 'h32);
    step(0, 0, 'h10, 0, 0, 0, 0, 0);
    step(0, 1, 'h30, 'h50, 0, 'h70, 0, 'h52);
    step(0, 0, 'h30, 0, 0, 0, 0, 0);
    // Same-cycle lookup/update: old target visible, new one next cycle.
    step(0, 1, 'h10, 'h10, 1, 'h40, 0, 'h12);
    step(0, 1, 'h10, 'h10, 1, 'h80, 1, 'h40);
    step(0, 0, 'h10, 0, 0, 0, 0, 0);
    // Reset dominates a concurrent update.
    step(1, 1, 'h20, 'h20, 1, 'h90, 0, 'h22);
    step(0, 0, 'h20, 0, 0, 0, 0, 0);
    step(0, 1, 'h20, 'h20, 1, 'h90, 0, 'h22);
    step(0, 1, 'h20, 'h20, 1, 'h90, 1, 'h90);
    step(0, 1, 'h20, 'h20, 0, 'h90, 1, 'h90);
    step(0, 0, 'h20, 0, 0, 0, 0, 0);
    // Wrap of PC+2 at the top of the address space.
    step(0, 1, 'hFFFE, 'hFFFE, 0, 0, 0, 0);

    for (int n = 0; n < 500; n++) begin
      pc_if = ($urandom_range(0, 63) << 1) | (($urandom_range(0, 7) == 0) ? 1 : 0);
      pc_id = ($urandom_range(0, 63) << 1);
      if ($urandom_range(0, 9) == 0) pc_id = pc_id | 'hFF80;
      if ($urandom_range(0, 2) == 0) pc_if = pc_id;
      tgt = $urandom_range(0, 7) << 4;
      act = 1'($urandom_range(0, 1));
      upd = 1'($urandom_range(0, 3) != 0);
      r   = 1'($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 0) begin
        pt  = 1'(m_taken(pc_id));
        ppc = m_pred_pc(pc_id);
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ppc = $urandom_range(0, 7) << 4;
      end
      step(r, upd, pc_if, pc_id, act, tgt, pt, ppc);
    end

`ifdef BP_STATS_EN
    // Drive both counters past 16'hFFFF and confirm they hold.
    for (int n = 0; n < 65540; n++) step(0, 1, 'h10, 'h10, 1, 'h40, 0, 'h12);
    step(0, 0, 'h10, 0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
